rob: RTL and testbench
======================

// Module: rob
// PURPOSE
//  Reorder buffer: accepts data packets tagged with a packet ID (PID) in any order and releases
//  them strictly in ascending PID order (modulo 2^p_PID_LEN). Packets are accepted only if their
//  PID falls inside a sliding window of p_ROB_SIZE IDs starting at the next PID to be released.
//  Sits between an out-of-order producer (e.g. a multi-path link receiver) and an in-order consumer.
// PARAMETERS
//  p_WORD_LEN  16  width of packet data word
//  p_PID_LEN   4   width of packet ID; PIDs wrap modulo 2^p_PID_LEN
//  p_ROB_SIZE  8   number of slots; power of two, 2 <= p_ROB_SIZE <= 2^p_PID_LEN
// PORTS
//  i_clk        in   1           clock; all state updates on rising edge
//  i_reset      in   1           synchronous, active-high reset
//  i_reset_pid  in   p_PID_LEN   PID loaded as window start during reset
//  o_min_pid    out  p_PID_LEN   window start = next PID to be released (registered)
//  o_max_pid    out  p_PID_LEN   window end = o_min_pid + p_ROB_SIZE - 1 (mod 2^p_PID_LEN)
//  i_inp_pid    in   p_PID_LEN   PID of incoming packet
//  i_inp_data   in   p_WORD_LEN  data of incoming packet
//  i_inp_en     in   1           write request for incoming packet
//  o_inp_ack    out  1           registered: 1 for one cycle after a write was stored
//  o_inp_valid  out  1           combinational: i_inp_pid is in window and its slot is empty
//  o_out_data   out  p_WORD_LEN  data of slot holding o_min_pid (combinational read)
//  i_out_en     in   1           pop request for head packet
//  o_out_valid  out  1           combinational: packet with PID o_min_pid is present
// BEHAVIOUR
//  - State: data array [p_ROB_SIZE], filled-bit array [p_ROB_SIZE], min_pid register, ack register.
//  - Slot index of a PID = PID[log2(p_ROB_SIZE)-1:0].
//  - offset = (i_inp_pid - o_min_pid) mod 2^p_PID_LEN; in-window iff offset < p_ROB_SIZE.
//  - Reset (i_reset=1 at edge): all filled bits <= 0, min_pid <= i_reset_pid, o_inp_ack <= 0;
//    data array contents don't care. Reset overrides any write/pop in the same cycle.
//  - After reset: o_min_pid = i_reset_pid, o_max_pid = i_reset_pid + p_ROB_SIZE - 1,
//    o_out_valid = 0, o_out_data don't care (slot contents are unspecified).
//  - Write: if i_inp_en && o_inp_valid, store i_inp_data in slot, set filled bit, o_inp_ack <= 1
//    next cycle; otherwise o_inp_ack <= 0. Out-of-window or duplicate (slot filled) PIDs are
//    dropped without modifying state; no overwrite of existing data.
//  - Pop: if i_out_en && o_out_valid, clear head filled bit, min_pid <= min_pid + 1 (wraps).
//    i_out_en with o_out_valid=0 is ignored. Throughput: one pop per cycle.
//  - Window test and o_inp_valid use pre-edge min_pid: in a cycle that pops, a write to
//    min_pid+p_ROB_SIZE is rejected; a write to the head PID is impossible (head slot filled).
//  - Simultaneous write and pop to different slots both take effect in the same cycle.
//  - Latency: packet written at edge N is poppable (o_out_valid=1) from edge N if it is the head.
//  - Full: all slots filled -> o_inp_valid=0 for every PID; pops still allowed.
// TESTING
//  1 reset with i_reset_pid=3 -> o_min_pid=3, o_max_pid=10, o_out_valid=0, o_inp_ack=0.
//  2 after reset_pid=0 write PIDs 2,1,0 (data=PID) -> ack each; o_out_valid rises only after
//    PID 0 stored; pop 3 cycles -> o_out_data 0,1,2; o_min_pid ends at 3, o_out_valid=0.
//  3 min_pid=0: write PID 8 -> o_inp_valid=0, no ack, state unchanged; PID 7 -> accepted.
//  4 duplicate: write PID 1 data 0xAAAA then PID 1 data 0xBBBB -> second no ack; pop yields 0xAAAA.
//  5 wrap: reset_pid=14, write 14,15,0,1 in order 1,0,15,14 -> pops give 14,15,0,1; o_min_pid=2.
//  6 fill 8 slots, then pop and write PID min+8 same cycle -> write rejected; next cycle accepted;
//    assert i_reset mid-stream -> all filled cleared, o_out_valid=0.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: stores out-of-order packets by PID slot and releases them in
// ascending PID order, accepting only PIDs within a window starting at the head.
module rob #(
  parameter int p_WORD_LEN = 16,
  parameter int p_PID_LEN  = 4,
  parameter int p_ROB_SIZE = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [p_PID_LEN-1:0]  i_reset_pid,
  output logic [p_PID_LEN-1:0]  o_min_pid,
  output logic [p_PID_LEN-1:0]  o_max_pid,
  input  logic [p_PID_LEN-1:0]  i_inp_pid,
  input  logic [p_WORD_LEN-1:0] i_inp_data,
  input  logic                  i_inp_en,
  output logic                  o_inp_ack,
  output logic                  o_inp_valid,
  output logic [p_WORD_LEN-1:0] o_out_data,
  input  logic                  i_out_en,
  output logic                  o_out_valid
);

  localparam int IDX_W = $clog2(p_ROB_SIZE);
  localparam logic [p_PID_LEN-1:0] SIZE_M1  = p_PID_LEN'(p_ROB_SIZE - 1);
  // One extra bit so a window covering the whole PID space still compares correctly.
  localparam logic [p_PID_LEN:0]   SIZE_EXT = (p_PID_LEN + 1)'(p_ROB_SIZE);

  logic [p_WORD_LEN-1:0] data_q [p_ROB_SIZE];
  logic [p_ROB_SIZE-1:0] filled_q, filled_d;
  logic [p_PID_LEN-1:0]  min_pid_q, min_pid_d;
  logic                  ack_q, ack_d;

  logic [p_PID_LEN-1:0]  offset;
  logic [IDX_W-1:0]      inp_idx, head_idx;
  logic                  in_window, wr_en, pop_en;

  assign offset    = i_inp_pid - min_pid_q;
  assign in_window = {1'b0, offset} < SIZE_EXT;
  assign inp_idx   = i_inp_pid[IDX_W-1:0];
  assign head_idx  = min_pid_q[IDX_W-1:0];

  assign o_inp_valid = in_window && !filled_q[inp_idx];
  assign o_out_valid = filled_q[head_idx];
  assign o_out_data  = data_q[head_idx];
  assign o_min_pid   = min_pid_q;
  assign o_max_pid   = min_pid_q + SIZE_M1;
  assign o_inp_ack   = ack_q;

  assign wr_en  = i_inp_en && o_inp_valid;
  assign pop_en = i_out_en && o_out_valid;

  // A write can never target the head slot while it pops: the head slot is filled then.
  always_comb begin
    filled_d  = filled_q;
    min_pid_d = min_pid_q;
    ack_d     = wr_en;
    if (wr_en) begin
      filled_d[inp_idx] = 1'b1;
    end
    if (pop_en) begin
      filled_d[head_idx] = 1'b0;
      min_pid_d          = min_pid_q + p_PID_LEN'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      filled_q  <= '0;
      min_pid_q <= i_reset_pid;
      ack_q     <= 1'b0;
    end else begin
      filled_q  <= filled_d;
      min_pid_q <= min_pid_d;
      ack_q     <= ack_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < p_ROB_SIZE; gi++) begin : g_slot
      always_ff @(posedge i_clk) begin
        if (wr_en && (inp_idx == IDX_W'(gi))) begin
          data_q[gi] <= i_inp_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_rob.sv
// Randomized and directed bench for rob, checked every cycle against a
// PID-indexed behavioural model of the reorder window.
module tb_rob;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [3:0]  i_reset_pid = 4'd0;
  logic [3:0]  o_min_pid, o_max_pid;
  logic [3:0]  i_inp_pid = 4'd0;
  logic [15:0] i_inp_data = 16'd0;
  logic        i_inp_en = 1'b0;
  logic        o_inp_ack, o_inp_valid;
  logic [15:0] o_out_data;
  logic        i_out_en = 1'b0;
  logic        o_out_valid;

  int checks = 0;
  int failures = 0;

  rob dut (
    .i_clk(clk), .i_reset(i_reset), .i_reset_pid(i_reset_pid),
    .o_min_pid(o_min_pid), .o_max_pid(o_max_pid),
    .i_inp_pid(i_inp_pid), .i_inp_data(i_inp_data), .i_inp_en(i_inp_en),
    .o_inp_ack(o_inp_ack), .o_inp_valid(o_inp_valid),
    .o_out_data(o_out_data), .i_out_en(i_out_en), .o_out_valid(o_out_valid)
  );

  always #5 clk = ~clk;

  // Model: presence and data kept per PID; the window is PIDs min..min+7 mod 16.
  bit          m_init = 1'b0;
  logic [3:0]  m_min;
  bit          m_present [16];
  logic [15:0] m_data [16];
  bit          m_ack;

  function automatic bit m_valid(input logic [3:0] pid);
    logic [3:0] off;
    off = pid - m_min;
    return (off < 4'd8) && !m_present[pid];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) m_present[i] = 1'b0;
      m_min  = i_reset_pid;
      m_ack  = 1'b0;
      m_init = 1'b1;
    end else begin
      automatic bit wr_ok  = i_inp_en && m_valid(i_inp_pid);
      automatic bit pop_ok = i_out_en && m_present[m_min];
      if (pop_ok) begin
        m_present[m_min] = 1'b0;
        m_min = m_min + 4'd1;
      end
      if (wr_ok) begin
        m_present[i_inp_pid] = 1'b1;
        m_data[i_inp_pid]    = i_inp_data;
      end
      m_ack = wr_ok;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      automatic logic [3:0] m_max = m_min + 4'd7;
      chk("min_pid", o_min_pid, m_min);
      chk("max_pid", o_max_pid, m_max);
      chk("out_valid", o_out_valid, m_present[m_min]);
      if (m_present[m_min]) chk("out_data", o_out_data, m_data[m_min]);
      chk("inp_valid", o_inp_valid, m_valid(i_inp_pid));
      chk("inp_ack", o_inp_ack, m_ack);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    i_reset  = 1'b0;
    i_inp_en = 1'b0;
    i_out_en = 1'b0;
  endtask

  task automatic do_reset(input logic [3:0] pid);
    i_reset = 1'b1;
    i_reset_pid = pid;
    step();
    $display("reset pid=%0d min=%0d max=%0d", pid, o_min_pid, o_max_pid);
  endtask

  task automatic wr(input logic [3:0] pid, input logic [15:0] data, input bit exp_ack);
    i_inp_pid = pid; i_inp_data = data; i_inp_en = 1'b1;
    step();
    $display("write pid=%0d data=%04h ack=%0b", pid, data, o_inp_ack);
    chk("wr_ack", o_inp_ack, exp_ack);
  endtask

  task automatic pop(input logic [15:0] exp_data);
    chk("pop_valid", o_out_valid, 1'b1);
    chk("pop_data", o_out_data, exp_data);
    $display("pop pid=%0d data=%04h", o_min_pid, o_out_data);
    i_out_en = 1'b1;
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    // 1: reset window
    do_reset(4'd3);
    chk("rst_min", o_min_pid, 4'd3);
    chk("rst_max", o_max_pid, 4'd10);
    chk("rst_valid", o_out_valid, 1'b0);
    chk("rst_ack", o_inp_ack, 1'b0);

    // 2: out-of-order writes then in-order pops
    do_reset(4'd0);
    wr(4'd2, 16'd2, 1'b1); chk("t2_v2", o_out_valid, 1'b0);
    wr(4'd1, 16'd1, 1'b1); chk("t2_v1", o_out_valid, 1'b0);
    wr(4'd0, 16'd0, 1'b1); chk("t2_v0", o_out_valid, 1'b1);
    pop(16'd0); pop(16'd1); pop(16'd2);
    chk("t2_min", o_min_pid, 4'd3);
    chk("t2_valid", o_out_valid, 1'b0);

    // 3: window edge
    do_reset(4'd0);
    i_inp_pid = 4'd8; #1;
    chk("t3_inv", o_inp_valid, 1'b0);
    wr(4'd8, 16'h0808, 1'b0);
    chk("t3_min", o_min_pid, 4'd0);
    wr(4'd7, 16'h0707, 1'b1);

    // 4: duplicates are dropped
    do_reset(4'd1);
    wr(4'd1, 16'hAAAA, 1'b1);
    wr(4'd1, 16'hBBBB, 1'b0);
    pop(16'hAAAA);

    // 5: PID wrap
    do_reset(4'd14);
    wr(4'd1, 16'd1, 1'b1); wr(4'd0, 16'd0, 1'b1);
    wr(4'd15, 16'd15, 1'b1); wr(4'd14, 16'd14, 1'b1);
    pop(16'd14); pop(16'd15); pop(16'd0); pop(16'd1);
    chk("t5_min", o_min_pid, 4'd2);

    // 6: full, pop plus write of min+8, reset mid-stream
    do_reset(4'd0);
    for (int p = 0; p < 8; p++) wr(4'(p), 16'(16'h100 + p), 1'b1);
    i_inp_pid = 4'd3; #1;
    chk("t6_full", o_inp_valid, 1'b0);
    i_inp_pid = 4'd8; i_inp_data = 16'h0888; i_inp_en = 1'b1; i_out_en = 1'b1;
    step();
    chk("t6_rej", o_inp_ack, 1'b0);
    chk("t6_min", o_min_pid, 4'd1);
    wr(4'd8, 16'h0888, 1'b1);
    i_inp_pid = 4'd9; i_inp_en = 1'b1; i_out_en = 1'b1; i_reset = 1'b1;
    step();
    chk("t6_rvalid", o_out_valid, 1'b0);
    chk("t6_rack", o_inp_ack, 1'b0);
    chk("t6_rmin", o_min_pid, 4'd0);

    // Random traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      i_reset     = ($urandom_range(0, 199) == 0);
      i_reset_pid = 4'($urandom);
      i_inp_pid   = o_min_pid + 4'($urandom_range(0, 9));
      i_inp_data  = 16'($urandom);
      i_inp_en    = ($urandom_range(0, 3) != 0);
      i_out_en    = ($urandom_range(0, 2) == 0);
      @(posedge clk);
      #1;
    end
    i_reset = 1'b0; i_inp_en = 1'b0; i_out_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
